// File: rtl/mips_id_ex_stage.sv
// -----------------------------------------------------------------------------
// mips_id_ex_stage
//   Decode/operand stage that feeds the 32-bit MIPS ALU. It holds the 32x32
//   register file, decodes id_instr into the ALU function code and operands,
//   and registers everything into the ID/EX pipeline register.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid/id_instr instruction presented this cycle
//   stall, flush      hold / squash the ID/EX register (flush wins)
//   wb_we/addr/data   register-file write port
//   ex_valid          ID/EX holds a live instruction
//   ex_A, ex_B, ex_F  ALU operands and function code
//   ex_wreg           destination register number
//   ex_regwrite, ex_memrd, ex_memwr, ex_illegal  control bits
//   ex_rt_data        rt value (store data)
//
// Handshake: there is no backpressure. An instruction is accepted at a rising
// edge when stall=0 and flush=0; id_valid qualifies it. ex_valid marks a live
// ID/EX entry, and every ex_* control bit reads 0 when ex_valid is 0.
//
// Configuration macro: MIPS_RF_BYPASS_EN
//   Defined   - a same-cycle write to rs/rt is forwarded to the read ports.
//   Undefined - reads return the stored contents; a write is visible next cycle.
// -----------------------------------------------------------------------------
module mips_id_ex_stage #(
    parameter int DATA_W          = 32,
    parameter bit REG_RESET_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_A,
    output logic [DATA_W-1:0] ex_B,
    output logic [2:0]        ex_F,
    output logic [4:0]        ex_wreg,
    output logic              ex_regwrite,
    output logic              ex_memrd,
    output logic              ex_memwr,
    output logic              ex_illegal,
    output logic [DATA_W-1:0] ex_rt_data
);

    // ------------------------------------------------------------------ RF
    logic [DATA_W-1:0] rf_q [32];
    logic [DATA_W-1:0] rf_d [32];

    always_comb begin
        rf_d = rf_q;
        if (wb_we && (wb_addr != 5'd0)) begin
            rf_d[wb_addr] = wb_data;
        end
        rf_d[0] = '0;
    end

    generate
        if (REG_RESET_CLEAR) begin : g_rf_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rf_q <= '{default: '0};
                end else begin
                    rf_q <= rf_d;
                end
            end
        end else begin : g_rf_noclear
            always_ff @(posedge clk) begin
                rf_q <= rf_d;
            end
        end
    endgenerate

    // ------------------------------------------------------------- Decode
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign opcode = id_instr[31:26];
    assign rs     = id_instr[25:21];
    assign rt     = id_instr[20:16];
    assign rd     = id_instr[15:11];
    assign imm    = id_instr[15:0];
    assign funct  = id_instr[5:0];

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    always_comb begin
        rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
        rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
`ifdef MIPS_RF_BYPASS_EN
        // Write-before-read: the incoming writeback value wins over the array.
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) rs_data = wb_data;
        if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) rt_data = wb_data;
`endif
    end

    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

    logic [DATA_W-1:0] dec_b;
    logic [2:0]        dec_f;
    logic [4:0]        dec_wreg;
    logic              dec_regwrite;
    logic              dec_memrd;
    logic              dec_memwr;
    logic              dec_illegal;

    always_comb begin
        dec_b        = rt_data;
        dec_f        = 3'b010;
        dec_wreg     = rt;
        dec_regwrite = 1'b0;
        dec_memrd    = 1'b0;
        dec_memwr    = 1'b0;
        dec_illegal  = 1'b0;
        case (opcode)
            6'b000000: begin
                dec_wreg     = rd;
                dec_regwrite = 1'b1;
                case (funct)
                    6'b100000: dec_f = 3'b010;
                    6'b100010: dec_f = 3'b110;
                    6'b100100: dec_f = 3'b000;
                    6'b100101: dec_f = 3'b001;
                    6'b101010: dec_f = 3'b111;
                    default: begin
                        dec_regwrite = 1'b0;
                        dec_illegal  = 1'b1;
                    end
                endcase
            end
            6'b001000: begin dec_b = imm_sext; dec_f = 3'b010; dec_regwrite = 1'b1; end
            6'b001010: begin dec_b = imm_sext; dec_f = 3'b111; dec_regwrite = 1'b1; end
            6'b001100: begin dec_b = imm_zext; dec_f = 3'b000; dec_regwrite = 1'b1; end
            6'b001101: begin dec_b = imm_zext; dec_f = 3'b001; dec_regwrite = 1'b1; end
            6'b100011: begin dec_b = imm_sext; dec_regwrite = 1'b1; dec_memrd = 1'b1; end
            6'b101011: begin dec_b = imm_sext; dec_memwr = 1'b1; end
            default:   dec_illegal = 1'b1;
        endcase
        // A result aimed at $0 is never written back.
        if (dec_wreg == 5'd0) dec_regwrite = 1'b0;
    end

    // -------------------------------------------------------------- ID/EX
    logic              ex_valid_q,    ex_valid_d;
    logic [DATA_W-1:0] ex_a_q,        ex_a_d;
    logic [DATA_W-1:0] ex_b_q,        ex_b_d;
    logic [2:0]        ex_f_q,        ex_f_d;
    logic [4:0]        ex_wreg_q,     ex_wreg_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memrd_q,    ex_memrd_d;
    logic              ex_memwr_q,    ex_memwr_d;
    logic              ex_illegal_q,  ex_illegal_d;
    logic [DATA_W-1:0] ex_rt_data_q,  ex_rt_data_d;

    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_a_d        = ex_a_q;
        ex_b_d        = ex_b_q;
        ex_f_d        = ex_f_q;
        ex_wreg_d     = ex_wreg_q;
        ex_regwrite_d = ex_regwrite_q;
        ex_memrd_d    = ex_memrd_q;
        ex_memwr_d    = ex_memwr_q;
        ex_illegal_d  = ex_illegal_q;
        ex_rt_data_d  = ex_rt_data_q;
        if (flush) begin
            // Bubble: only the control bits matter; datapath fields keep old values.
            ex_valid_d    = 1'b0;
            ex_regwrite_d = 1'b0;
            ex_memrd_d    = 1'b0;
            ex_memwr_d    = 1'b0;
            ex_illegal_d  = 1'b0;
        end else if (!stall) begin
            ex_valid_d    = id_valid;
            ex_a_d        = rs_data;
            ex_b_d        = dec_b;
            ex_f_d        = dec_f;
            ex_wreg_d     = dec_wreg;
            ex_regwrite_d = dec_regwrite & id_valid;
            ex_memrd_d    = dec_memrd    & id_valid;
            ex_memwr_d    = dec_memwr    & id_valid;
            ex_illegal_d  = dec_illegal  & id_valid;
            ex_rt_data_d  = rt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_f_q        <= 3'b000;
            ex_wreg_q     <= 5'd0;
            ex_regwrite_q <= 1'b0;
            ex_memrd_q    <= 1'b0;
            ex_memwr_q    <= 1'b0;
            ex_illegal_q  <= 1'b0;
            ex_rt_data_q  <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_f_q        <= ex_f_d;
            ex_wreg_q     <= ex_wreg_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memrd_q    <= ex_memrd_d;
            ex_memwr_q    <= ex_memwr_d;
            ex_illegal_q  <= ex_illegal_d;
            ex_rt_data_q  <= ex_rt_data_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_A        = ex_a_q;
    assign ex_B        = ex_b_q;
    assign ex_F        = ex_f_q;
    assign ex_wreg     = ex_wreg_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memrd    = ex_memrd_q;
    assign ex_memwr    = ex_memwr_q;
    assign ex_illegal  = ex_illegal_q;
    assign ex_rt_data  = ex_rt_data_q;

endmodule
